imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle RV32I CPU's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, writes them sequentially into instruction memory from address 0, and holds the CPU in reset until a complete, checksum-verified image is in place. Once released, the CPU fetches from address 0 with no further involvement from this block.

---
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the RV32I instruction memory.
// Receives a byte stream (LEN_LO, LEN_HI, 4*N data bytes LSB first, XOR checksum).
// It assembles little-endian 32-bit words and writes them from address 0 upward.
// The CPU is held in reset until the whole image is present and the checksum matches.
//
// Handshake: a byte transfers on a rising clk edge when rx_valid & rx_ready are
// both 1. rx_ready depends only on the current state, never on rx_valid. A byte
// offered while rx_ready is 0 stays with the sender. While rx_valid is low in an
// accepting state, state, counters and checksum all hold.
module imem_loader #(
    parameter int DEPTH_WORDS = 32,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_reset,
    output logic          done,
    output logic          err,
    output logic [2:0]    state_dbg
);

    localparam int WIW = $clog2(DEPTH_WORDS) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN0   = 3'd1,
        S_LEN1   = 3'd2,
        S_DATA   = 3'd3,
        S_COMMIT = 3'd4,
        S_CSUM   = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [15:0]    len;
    logic [1:0]     byte_idx;
    logic [WIW-1:0] word_idx;
    logic [31:0]    word;
    logic [7:0]     csum;

    logic           accept;
    logic [15:0]    len_full;
    logic           last_word;

    assign accept    = rx_valid & rx_ready;
    // The full length, as it will be once the LEN_HI byte on the bus is accepted.
    assign len_full  = {rx_data, len[7:0]};
    // The word being committed is the final one of the image.
    assign last_word = ((16'(word_idx) + 16'd1) == len);

    // The address is word-aligned and zero-extended. The data is the assembled word.
    assign imem_waddr = AW'({word_idx, 2'b00});
    assign imem_wdata = word;
    assign state_dbg  = state;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_LEN0;
            S_LEN0:   if (accept) state_nxt = S_LEN1;
            S_LEN1: begin
                if (accept) begin
                    if (len_full > 16'(DEPTH_WORDS)) begin
                        state_nxt = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_nxt = S_CSUM;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA:   if (accept && byte_idx == 2'd3) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = last_word ? S_CSUM : S_DATA;
            S_CSUM: begin
                if (accept) begin
                    state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE:   state_nxt = S_DONE;
            S_ERR:    state_nxt = S_ERR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs. The CPU stays in reset everywhere except DONE.
    always_comb begin
        rx_ready  = 1'b0;
        imem_we   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        cpu_reset = 1'b1;
        case (state)
            S_LEN0, S_LEN1, S_DATA, S_CSUM: rx_ready = 1'b1;
            S_COMMIT: imem_we = 1'b1;
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            S_ERR:    err = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: length capture, word assembly, word counter and running checksum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len      <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            word     <= '0;
            csum     <= '0;
        end else begin
            case (state)
                S_LEN0: begin
                    if (accept) len[7:0] <= rx_data;
                end
                S_LEN1: begin
                    // A fresh image starts at word 0 with an empty checksum.
                    if (accept) begin
                        len[15:8] <= rx_data;
                        byte_idx  <= '0;
                        word_idx  <= '0;
                        csum      <= '0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word[{byte_idx, 3'b000} +: 8] <= rx_data;
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                S_COMMIT: word_idx <= word_idx + WIW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. It uses directed and random byte-stream images.
// An image-level reference model predicts the writes and the final outcome.
module tb_imem_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          err;
    logic [2:0]    state_dbg;

    imem_loader #(.DEPTH_WORDS(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // Clock and free-running cycle counter
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard state
    logic [7:0]    stream[$];
    logic [63:0]   exp_q[$];
    bit            exp_done;
    bit            exp_err;
    int            exp_consume;
    int            exp_n;
    int            rel_cyc;
    int            n_checks = 0;
    int            n_err    = 0;
    logic [31:0]   last_wdata;
    logic [AW-1:0] last_waddr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Write monitor: each memory write must be the next one the model predicted.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (reset === 1'b1 && imem_we === 1'b1) begin
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            check("ready_low_in_commit", 64'(rx_ready), 64'd0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_addr_data", {imem_waddr, imem_wdata}, e);
            end
            last_waddr = imem_waddr;
            last_wdata = imem_wdata;
        end
    end

    // Reference model: stream bytes -> expected writes, outcome and bytes consumed
    task automatic model_image();
        logic [7:0]  cs;
        logic [31:0] w;
        exp_n   = int'(stream[0]) + 256 * int'(stream[1]);
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        if (exp_n > DEPTH) begin
            exp_err     = 1;
            exp_consume = 2;
        end else begin
            cs = 8'h00;
            for (int i = 0; i < exp_n; i++) begin
                w = 32'h0;
                for (int b = 0; b < 4; b++) begin
                    w  = w | (32'(stream[2 + 4*i + b]) << (8*b));
                    cs = cs ^ stream[2 + 4*i + b];
                end
                exp_q.push_back({32'(i * 4), w});
            end
            exp_consume = 2 + 4*exp_n + 1;
            if (stream[2 + 4*exp_n] == cs) exp_done = 1;
            else                           exp_err  = 1;
        end
    endtask

    task automatic build_image(input int n, input bit corrupt);
        logic [7:0] cs;
        logic [7:0] b;
        logic [15:0] n16;
        n16 = 16'(n);
        stream.delete();
        stream.push_back(n16[7:0]);
        stream.push_back(n16[15:8]);
        cs = 8'h00;
        for (int i = 0; i < 4*n; i++) begin
            b  = 8'($urandom);
            cs = cs ^ b;
            stream.push_back(b);
        end
        if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
        stream.push_back(cs);
    endtask

    task automatic reset_checks();
        check("rst_rx_ready",   64'(rx_ready),   64'd0);
        check("rst_imem_we",    64'(imem_we),    64'd0);
        check("rst_imem_waddr", 64'(imem_waddr), 64'd0);
        check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        check("rst_cpu_reset",  64'(cpu_reset),  64'd1);
        check("rst_done",       64'(done),       64'd0);
        check("rst_err",        64'(err),        64'd0);
    endtask

    // Asynchronous reset mid-cycle, then release away from the clock edge
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset    = 1'b0;
        rx_valid = 1'b0;
        #1;
        reset_checks();
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b1;
        rel_cyc = cyc_cnt;
        exp_q.delete();
        check("ready_at_release", 64'(rx_ready), 64'd0);
    endtask

    task automatic start();
        do_reset();
        @(posedge clk);
        #1;
        check("ready_after_release", 64'(rx_ready), 64'd1);
    endtask

    // Byte driver. mode 0: valid held high, 1: toggled every cycle, 2: random.
    task automatic send(input int count, input int mode);
        int   idx   = 0;
        int   guard = 0;
        bit   tog   = 1'b1;
        logic hs;
        while (idx < count && guard < 4000) begin
            rx_data = stream[idx];
            case (mode)
                0:       rx_valid = 1'b1;
                1: begin
                    rx_valid = tog;
                    tog      = ~tog;
                end
                default: rx_valid = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            hs = rx_valid & rx_ready;
            @(posedge clk);
            #1;
            if (hs) idx++;
            guard++;
        end
        rx_valid = 1'b0;
        check("bytes_accepted", 64'(idx), 64'(count));
    endtask

    // Outcome right after the last accepted byte, then the terminal state holds
    task automatic finish_check();
        check("done",      64'(done),      64'(exp_done));
        check("err",       64'(err),       64'(exp_err));
        check("cpu_reset", 64'(cpu_reset), 64'(!exp_done));
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        repeat (3) begin
            @(negedge clk);
            check("ready_terminal", 64'(rx_ready), 64'd0);
        end
        rx_valid = 1'b0;
        check("done_sticky", 64'(done), 64'(exp_done));
        check("err_sticky",  64'(err),  64'(exp_err));
        check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_image(input int mode);
        model_image();
        start();
        model_image();
        send(exp_consume, mode);
        if (mode == 0 && exp_done) begin
            check("image_cycles", 64'(cyc_cnt - rel_cyc), 64'(4 + 5*exp_n));
        end
        finish_check();
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed steps followed by random images
    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Single word image
        stream = '{8'h01, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h33};
        run_image(0);
        check("single_waddr", 64'(last_waddr), 64'h0);
        check("single_wdata", 64'(last_wdata), 64'h00A00093);

        // Three words with rx_valid toggling
        build_image(3, 1'b0);
        run_image(1);
        check("three_last_waddr", 64'(last_waddr), 64'h8);

        // Bad checksum
        stream = '{8'h01, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h34};
        run_image(0);

        // Length overflow (33 words)
        stream = '{8'h21, 8'h00};
        run_image(0);

        // Zero-length images
        stream = '{8'h00, 8'h00, 8'h00};
        run_image(0);
        stream = '{8'h00, 8'h00, 8'hFF};
        run_image(0);

        // Reset asserted after 6 data bytes of a 2-word image
        build_image(2, 1'b0);
        model_image();
        start();
        model_image();
        send(8, 0);
        check("writes_before_reset", 64'(exp_q.size()), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        reset_checks();
        build_image(1, 1'b0);
        run_image(0);
        check("reload_waddr", 64'(last_waddr), 64'h0);

        // Random images including the full-depth and one-past boundaries
        for (int it = 0; it < 8; it++) begin
            int n;
            n = (it == 0) ? DEPTH : (it == 1) ? DEPTH + 1 : int'($urandom_range(0, DEPTH + 4));
            build_image(n, ($urandom_range(0, 3) == 0));
            run_image(int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
